// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and width helpers for the mem_arbiter block and its picker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Down-counter width able to hold the value lat.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner select: round-robin from last+1 when MEMARB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority with the lowest index winning.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int IDX_W  = idx_width(NCORES)
) (
`ifdef MEMARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]  last,
`endif
  input  logic [NCORES-1:0] req,
  output logic [NCORES-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

`ifdef MEMARB_ROUND_ROBIN_EN
  // Walk the cores cyclically starting just after the previous winner.
  always_comb begin
    logic [IDX_W-1:0] pos;
    logic             found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NCORES; k++) begin
      pos = IDX_W'((int'(last) + k) % NCORES);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM among NCORES cores; round-robin arbitration
// with MEMARB_ROUND_ROBIN_EN defined, fixed lowest-index priority otherwise.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        rden,
  input  logic [NCORES-1:0]        wren,
  input  logic [NCORES*ADDR_W-1:0] Address,
  input  logic [NCORES*DATA_W-1:0] Din,
  output logic [NCORES*DATA_W-1:0] Dq,
  output logic [NCORES-1:0]        acq,
  output logic [NCORES-1:0]        ack,
  output logic [ADDR_W-1:0]        RAMAddress,
  output logic [DATA_W-1:0]        RAMDin,
  output logic                     RAMwren,
  input  logic [DATA_W-1:0]        RAMq
);

  localparam int IDX_W = idx_width(NCORES);
  localparam int CNT_W = cnt_width(RAM_LAT);

  arb_state_e        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  pick_idx;
  logic [NCORES-1:0] req;
  logic [NCORES-1:0] pick_grant;
  logic              wr_flag;

  assign req = rden | wren;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last;

  // Reset points last at the top core so core 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDX_W'(NCORES - 1);
    end else if (state == IDLE && |req) begin
      last <= pick_idx;
    end
  end

  rr_pick #(
    .NCORES(NCORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .last (last),
    .req  (req),
    .grant(pick_grant),
    .idx  (pick_idx)
  );
`else
  rr_pick #(
    .NCORES(NCORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req),
    .grant(pick_grant),
    .idx  (pick_idx)
  );
`endif

  // Grant captured in IDLE is presented to the RAM in ISSUE; the RAM port keeps
  // its last address/data afterwards and only the write strobe is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      win        <= '0;
      wr_flag    <= 1'b0;
      acq        <= '0;
      ack        <= '0;
      Dq         <= '0;
      RAMAddress <= '0;
      RAMDin     <= '0;
      RAMwren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win        <= pick_idx;
            acq        <= pick_grant;
            wr_flag    <= wren[pick_idx];
            RAMAddress <= Address[pick_idx*ADDR_W +: ADDR_W];
            RAMDin     <= Din[pick_idx*DATA_W +: DATA_W];
            RAMwren    <= wren[pick_idx];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          RAMwren  <= 1'b0;
          wait_cnt <= CNT_W'(RAM_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            if (!wr_flag) begin
              Dq[win*DATA_W +: DATA_W] <= RAMq;
            end
            ack   <= acq;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          ack   <= '0;
          acq   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 4-core RAM_LAT=1 instance and a 2-core RAM_LAT=3 instance.
module tb_mem_arbiter;

  localparam int NC = 4;
  localparam int NB = 2;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    int         core;
    logic       rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Four-core instance, RAM latency 1
  logic [NC-1:0]   rden = '0;
  logic [NC-1:0]   wren = '0;
  logic [NC*8-1:0] Address = '0;
  logic [NC*8-1:0] Din = '0;
  logic [NC*8-1:0] Dq;
  logic [NC-1:0]   acq;
  logic [NC-1:0]   ack;
  logic [7:0]      RAMAddress;
  logic [7:0]      RAMDin;
  logic            RAMwren;
  logic [7:0]      RAMq = '0;

  mem_arbiter #(
    .NCORES (NC),
    .ADDR_W (8),
    .DATA_W (8),
    .RAM_LAT(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rden      (rden),
    .wren      (wren),
    .Address   (Address),
    .Din       (Din),
    .Dq        (Dq),
    .acq       (acq),
    .ack       (ack),
    .RAMAddress(RAMAddress),
    .RAMDin    (RAMDin),
    .RAMwren   (RAMwren),
    .RAMq      (RAMq)
  );

  // Two-core instance, RAM latency 3
  logic [NB-1:0]   rden_b = '0;
  logic [NB-1:0]   wren_b = '0;
  logic [NB*8-1:0] Address_b = '0;
  logic [NB*8-1:0] Din_b = '0;
  logic [NB*8-1:0] Dq_b;
  logic [NB-1:0]   acq_b;
  logic [NB-1:0]   ack_b;
  logic [7:0]      RAMAddress_b;
  logic [7:0]      RAMDin_b;
  logic            RAMwren_b;
  logic [7:0]      RAMq_b = '0;

  mem_arbiter #(
    .NCORES (NB),
    .ADDR_W (8),
    .DATA_W (8),
    .RAM_LAT(3)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .rden      (rden_b),
    .wren      (wren_b),
    .Address   (Address_b),
    .Din       (Din_b),
    .Dq        (Dq_b),
    .acq       (acq_b),
    .ack       (ack_b),
    .RAMAddress(RAMAddress_b),
    .RAMDin    (RAMDin_b),
    .RAMwren   (RAMwren_b),
    .RAMq      (RAMq_b)
  );

  // RAM models; contents are preloaded whenever reset is high
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] pipe_b [2];

  always @(posedge clk) begin
    RAMq <= mem_a[RAMAddress];
    if (RAMwren) mem_a[RAMAddress] = RAMDin;
    if (rst) begin
      mem_a[8'h10] = 8'hA5;
      for (int i = 0; i < 5; i++) mem_a[8'h20 + i] = 8'h50 + 8'(i);
    end
  end

  always @(posedge clk) begin
    RAMq_b    <= pipe_b[1];
    pipe_b[1] <= pipe_b[0];
    pipe_b[0] <= mem_b[RAMAddress_b];
    if (RAMwren_b) mem_b[RAMAddress_b] = RAMDin_b;
    if (rst) begin
      mem_b[8'h40] = 8'hC3;
      mem_b[8'h41] = 8'h5E;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core models for the four-core instance: each core issues queued commands,
  // drops its request when it sees ack, then stays quiet for two cycles.
  cmd_t cmds [NC][8];
  int   cmd_head [NC] = '{default: 0};
  int   cmd_tail [NC] = '{default: 0};
  int   cool [NC] = '{default: 0};
  logic [NC-1:0] busy = '0;

  always @(negedge clk) begin
    cmd_t c;
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        busy[i] = 1'b0; cool[i] = 0; rden[i] = 1'b0; wren[i] = 1'b0;
      end else if (ack[i]) begin
        busy[i] = 1'b0; rden[i] = 1'b0; wren[i] = 1'b0; cool[i] = 2;
      end else if (cool[i] != 0) begin
        cool[i]--;
      end else if (!busy[i] && cmd_head[i] != cmd_tail[i]) begin
        c = cmds[i][cmd_head[i] % 8];
        cmd_head[i]++;
        busy[i] = 1'b1;
        rden[i] = c.rd;
        wren[i] = c.wr;
        Address[i*8 +: 8] = c.addr;
        Din[i*8 +: 8] = c.data;
      end
    end
  end

  exp_t       expq [$];
  exp_t       expq_b [$];
  logic [7:0] dq_model [NC];
  logic [7:0] dq_model_b [NB];

  // Monitors: pop an expectation on every ack and compare grant, timing and Dq.
  always @(negedge clk) begin
    exp_t e;
    logic [NC*8-1:0] dq_exp;
    if (rst) begin
      for (int i = 0; i < NC; i++) dq_model[i] = '0;
    end else if (ack != '0) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_ack", 64'(ack), 64'd0);
      end else begin
        e = expq.pop_front();
        checkOutput("ack_core", 64'(ack), 64'd1 << e.core);
        if (e.cyc >= 0) checkOutput("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.rd) dq_model[e.core] = e.data;
        for (int i = 0; i < NC; i++) dq_exp[i*8 +: 8] = dq_model[i];
        checkOutput("dq", 64'(Dq), 64'(dq_exp));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [NB*8-1:0] dq_exp;
    if (rst) begin
      for (int i = 0; i < NB; i++) dq_model_b[i] = '0;
    end else if (ack_b != '0) begin
      if (expq_b.size() == 0) begin
        checkOutput("b_unexpected_ack", 64'(ack_b), 64'd0);
      end else begin
        e = expq_b.pop_front();
        checkOutput("b_ack_core", 64'(ack_b), 64'd1 << e.core);
        checkOutput("b_ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.rd) dq_model_b[e.core] = e.data;
        for (int i = 0; i < NB; i++) dq_exp[i*8 +: 8] = dq_model_b[i];
        checkOutput("b_dq", 64'(Dq_b), 64'(dq_exp));
      end
    end
  end

  task automatic applyStimulus(input int core, input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [7:0] data);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = addr; c.data = data;
    cmds[core][cmd_tail[core] % 8] = c;
    cmd_tail[core]++;
  endtask

  task automatic expectResp(input int core, input logic rd, input logic [7:0] data, input int at);
    exp_t e;
    e.core = core; e.rd = rd; e.data = data; e.cyc = at;
    expq.push_back(e);
  endtask

  task automatic atNeg(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic waitDone(input string name);
    int k;
    k = 0;
    while (expq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (expq.size() != 0) begin
      checkOutput({name, "_timeout"}, 64'(expq.size()), 64'd0);
      expq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic serveB(input int core, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    e.core = core; e.rd = 1'b1; e.data = data; e.cyc = cyc + 5;
    expq_b.push_back(e);
    rden_b[core] = 1'b1;
    Address_b[core*8 +: 8] = addr;
    k = 0;
    while (!ack_b[core] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ack_b[core]) begin
      checkOutput("b_ack_timeout", 64'(ack_b[core]), 64'd1);
      expq_b.delete();
    end
    rden_b[core] = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_acq", 64'(acq), 64'd0);
    checkOutput("rst_ack", 64'(ack), 64'd0);
    checkOutput("rst_dq", 64'(Dq), 64'd0);
    checkOutput("rst_ram_addr", 64'(RAMAddress), 64'd0);
    checkOutput("rst_ram_din", 64'(RAMDin), 64'd0);
    checkOutput("rst_ram_wren", 64'(RAMwren), 64'd0);
    checkOutput("rst_b_acq", 64'(acq_b), 64'd0);
    checkOutput("rst_b_dq", 64'(Dq_b), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read by core 0
    @(posedge clk); #1;
    n = cyc;
    applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00);
    expectResp(0, 1'b1, 8'hA5, n + 3);
    atNeg(n + 1);
    checkOutput("t1_issue_acq", 64'(acq), 64'h1);
    checkOutput("t1_issue_addr", 64'(RAMAddress), 64'h10);
    checkOutput("t1_issue_wren", 64'(RAMwren), 64'd0);
    waitDone("t1");

    // Core 0 writes while core 1 reads the same address
    doReset();
    n = cyc;
    applyStimulus(0, 1'b0, 1'b1, 8'h05, 8'h3C);
    applyStimulus(1, 1'b1, 1'b0, 8'h05, 8'h00);
    expectResp(0, 1'b0, 8'h00, n + 3);
    expectResp(1, 1'b1, 8'h3C, n + 7);
    atNeg(n + 1);
    checkOutput("t2_issue_wren", 64'(RAMwren), 64'd1);
    checkOutput("t2_issue_addr", 64'(RAMAddress), 64'h05);
    checkOutput("t2_issue_din", 64'(RAMDin), 64'h3C);
    checkOutput("t2_issue_acq", 64'(acq), 64'h1);
    atNeg(n + 2);
    checkOutput("t2_wait_wren", 64'(RAMwren), 64'd0);
    atNeg(n + 5);
    checkOutput("t2_second_acq", 64'(acq), 64'h2);
    checkOutput("t2_second_wren", 64'(RAMwren), 64'd0);
    waitDone("t2");

    // All four cores requesting back to back
    doReset();
    n = cyc;
    applyStimulus(0, 1'b1, 1'b0, 8'h20, 8'h00);
    applyStimulus(0, 1'b1, 1'b0, 8'h24, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 8'h21, 8'h00);
    applyStimulus(2, 1'b1, 1'b0, 8'h22, 8'h00);
    applyStimulus(3, 1'b1, 1'b0, 8'h23, 8'h00);
`ifdef MEMARB_ROUND_ROBIN_EN
    expectResp(0, 1'b1, 8'h50, n + 3);
    expectResp(1, 1'b1, 8'h51, n + 7);
    expectResp(2, 1'b1, 8'h52, n + 11);
    expectResp(3, 1'b1, 8'h53, n + 15);
    expectResp(0, 1'b1, 8'h54, n + 19);
`else
    expectResp(0, 1'b1, 8'h50, n + 3);
    expectResp(1, 1'b1, 8'h51, n + 7);
    expectResp(0, 1'b1, 8'h54, n + 11);
    expectResp(2, 1'b1, 8'h52, n + 15);
    expectResp(3, 1'b1, 8'h53, n + 19);
`endif
    atNeg(n + 5);
    checkOutput("t3_second_acq", 64'(acq), 64'h2);
    waitDone("t3");

    // rden and wren together on core 1 is a write; read it back afterwards
    n = cyc;
    applyStimulus(1, 1'b1, 1'b1, 8'h30, 8'h77);
    applyStimulus(1, 1'b1, 1'b0, 8'h30, 8'h00);
    expectResp(1, 1'b0, 8'h00, n + 3);
    expectResp(1, 1'b1, 8'h77, n + 9);
    atNeg(n + 1);
    checkOutput("t4_issue_wren", 64'(RAMwren), 64'd1);
    checkOutput("t4_issue_din", 64'(RAMDin), 64'h77);
    checkOutput("t4_issue_acq", 64'(acq), 64'h2);
    waitDone("t4");

    // Latency-3 read
    serveB(0, 8'h40, 8'hC3);

    // Reset in the middle of a latency-3 read
    @(posedge clk); #1;
    rden_b[1] = 1'b1;
    Address_b[15:8] = 8'h41;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_wait_acq", 64'(acq_b), 64'h2);
    rst = 1'b1;
    rden_b[1] = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_rst_acq", 64'(acq_b), 64'd0);
    checkOutput("t6_rst_ack", 64'(ack_b), 64'd0);
    checkOutput("t6_rst_dq", 64'(Dq_b), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t6_no_ack", 64'(ack_b), 64'd0);
    end
    serveB(1, 8'h41, 8'h5E);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised shared-RAM arbiter for the multicore processor. It accepts per-core read/write requests and grants one core at a time, using round-robin rotation. It drives a single synchronous single-port RAM with configurable read latency and returns read data and a one-cycle `ack` to the winning core. It replaces the fixed two-core, 8-bit controller and supports any core count and any address/data width.

## Interface
- `NCORES`, 2: number of requesting cores (≥1)
- `ADDR_W`, 8: RAM address width
- `DATA_W`, 8: RAM data width
- `RAM_LAT`, 1: RAM read latency in cycles (≥1)

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `rden` in NCORES: per-core read request
- `wren` in NCORES: per-core write request
- `Address` in NCORES*ADDR_W: core i at `[i*ADDR_W +: ADDR_W]`
- `Din` in NCORES*DATA_W: core i write data at `[i*DATA_W +: DATA_W]`
- `Dq` out NCORES*DATA_W: core i read data, same slicing
- `acq` out NCORES: one-hot grant
- `ack` out NCORES: one-cycle completion pulse
- `RAMAddress` out ADDR_W: RAM address
- `RAMDin` out DATA_W: RAM write data
- `RAMwren` out 1: RAM write enable
- `RAMq` in DATA_W: RAM read data

## Operation
- Request for core i: `req[i] = rden[i] | wren[i]`. If both are high, the access is a write.
- A core holds `rden`/`wren`, `Address` and `Din` stable until it sees `ack[i]`. It deasserts the request on the edge that ends the `ack` cycle.
- FSM states:
  - IDLE: arbitrate. If any request is present, register the winner `w` and the RAM port values, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: 1 cycle. `RAMAddress`/`RAMDin` hold core w's slice. `RAMwren` = write flag.
  - WAIT: RAM_LAT cycles, counted by a down-counter of width clog2(RAM_LAT+1). On the final WAIT cycle, a read captures `RAMq` into Dq slice w. Set `ack[w]`.
  - RESP: 1 cycle with `ack[w]` high, then go to IDLE.
- `acq[w]` is high from ISSUE through RESP inclusive. All other `acq` bits are 0.
- Arbitration: search cyclically starting at `last+1`. `last` updates to w on each grant. Requests that arrive after IDLE wait for the next IDLE.
- Dq slice i changes only on a read completion for core i. Write completions leave Dq unchanged.
- `RAMwren` is high only in ISSUE of a write. `RAMAddress`/`RAMDin` hold their last value outside ISSUE.
- Reset values: state IDLE, `acq`=0, `ack`=0, `Dq`=0, `RAMAddress`=0, `RAMDin`=0, `RAMwren`=0, `last`=NCORES-1 (so core 0 wins first).
- Reset asserted mid-transaction: the transaction is abandoned, no `ack` is issued, and the requesting core must re-request.

## Timing
- Request sampled in IDLE at cycle 0 → ISSUE in cycle 1 → WAIT in cycles 2..RAM_LAT+1 → `ack` and valid Dq in cycle RAM_LAT+2 → IDLE in cycle RAM_LAT+3.
- Service time per transaction: RAM_LAT+3 cycles. With RAM_LAT=1, `ack` arrives in cycle 3 and the next grant is issued in cycle 4.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MEMARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described above.
- Undefined: fixed priority, lowest index wins. `last` is removed. Timing is otherwise identical.

## Structure
- Package `mem_arbiter_pkg`: state enum (IDLE, ISSUE, WAIT, RESP) and a clog2-based width localparam helper.
- Sub-module `rr_pick`: combinational. Inputs are `req` and `last`; outputs are the one-hot winner and its index. It also implements fixed priority when `MEMARB_ROUND_ROBIN_EN` is undefined.

## Test plan
- Reset check (NCORES=2, RAM_LAT=1): all outputs 0. Core 0 reads address 0x10 and the RAM model returns 0xA5 → `ack[0]` in cycle 3 with Dq[7:0]=0xA5, and Dq[15:8] is unchanged.
- Simultaneous requests: core 0 writes 0x3C to 0x05 while core 1 reads 0x05 → core 0 is served first (`RAMwren`=1 in ISSUE), then core 1 reads 0x3C.
- Round robin (NCORES=4): all cores hold continuous requests → grant order is 0,1,2,3,0 with one grant every 4 cycles.
- Latency (RAM_LAT=3): a read gets `ack` in cycle 5 and the captured data matches the RAM model.
- Reset asserted during WAIT → no `ack`, `acq`=0 next cycle, and the next request is served normally.
- `rden` and `wren` both high on core 1 → the access is a write and Dq[15:8] is unchanged.
